// File: rtl/l2_cache_wb.sv
`default_nettype none
// ============================================================================
// Module      : l2_cache_wb
// Description : N-way set-associative, write-back, write-allocate L2 cache
//               with true-LRU replacement. It moves whole blocks to and from
//               the L1 and main memory over flat buses. A dirty victim is
//               written back only when it is evicted. A full-block write
//               miss installs the block without fetching it from memory.
// Ports       : clk, rst_n (async, active low)
//               L1 side : l1_cache_addr, l1_cache_data_in_flat,
//                         l1_cache_read, l1_cache_write,
//                         l1_block_data_out_flat, l1_cache_ready,
//                         l1_cache_hit
//               Memory  : mem_data_block_flat, mem_ready, mem_addr,
//                         mem_data_out_flat, mem_read, mem_write
//               Optional: perf_hit_count, perf_miss_count, perf_wb_count
//                         (present when L2_CACHE_WB_PERF_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
module l2_cache_wb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int BLOCK_SIZE = 8,
  parameter int CACHE_SIZE = 64,
  parameter int NUM_WAYS   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [ADDR_WIDTH-1:0]                l1_cache_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]     l1_cache_data_in_flat,
  input  logic                                 l1_cache_read,
  input  logic                                 l1_cache_write,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]     l1_block_data_out_flat,
  output logic                                 l1_cache_ready,
  output logic                                 l1_cache_hit,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]     mem_data_block_flat,
  input  logic                                 mem_ready,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]     mem_data_out_flat,
  output logic                                 mem_read,
  output logic                                 mem_write
`ifdef L2_CACHE_WB_PERF_EN
  ,
  output logic [31:0]                          perf_hit_count,
  output logic [31:0]                          perf_miss_count,
  output logic [31:0]                          perf_wb_count
`endif
);

  localparam int SETS  = CACHE_SIZE / (BLOCK_SIZE * NUM_WAYS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int BW    = BLOCK_SIZE * DATA_WIDTH;

  typedef logic [NUM_WAYS-1:0][WAY_W-1:0] age_vec_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_FILL      = 3'd3,
    S_RESPOND   = 3'd4
  } state_t;

  // Line storage
  logic             r_valid [SETS][NUM_WAYS];
  logic             r_dirty [SETS][NUM_WAYS];
  logic [TAG_W-1:0] r_tag   [SETS][NUM_WAYS];
  logic [BW-1:0]    r_data  [SETS][NUM_WAYS];
  age_vec_t         r_age   [SETS];

  // Request context
  state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BW-1:0]      r_wdata;
  logic               r_is_write;
  logic [WAY_W-1:0]   r_way;
  logic               r_hit;
  logic [BW-1:0]      r_resp_data;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic [WAY_W-1:0]   w_hit_way;
  logic               w_has_inv;
  logic [WAY_W-1:0]   w_inv_way;
  logic [WAY_W-1:0]   w_old_way;
  logic [WAY_W-1:0]   w_max_age;
  logic [WAY_W-1:0]   w_victim;
  logic               w_victim_dirty;

  // Line write / LRU touch controls, shared by every install path
  logic               w_wr_en;
  logic [WAY_W-1:0]   w_wr_way;
  logic [BW-1:0]      w_wr_data;
  logic               w_wr_dirty;
  logic               w_touch;
  logic [WAY_W-1:0]   w_touch_way;

  assign w_idx = r_addr[IDX_W-1:0];
  assign w_tag = r_addr[ADDR_WIDTH-1:IDX_W];

  // The touched way becomes youngest; only ways that were younger than it age.
  // Ages therefore remain a permutation of 0..NUM_WAYS-1 within each set.
  function automatic age_vec_t lru_touch(input age_vec_t ages, input logic [WAY_W-1:0] way);
    age_vec_t         nxt;
    logic [WAY_W-1:0] old;
    old = ages[way];
    nxt = ages;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == way)
        nxt[w] = '0;
      else if (ages[w] < old)
        nxt[w] = ages[w] + WAY_W'(1);
    end
    return nxt;
  endfunction

  // Tag match and victim selection for the latched request
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    w_old_way = '0;
    w_max_age = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_hit && r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!w_has_inv && !r_valid[w_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
      if (r_age[w_idx][w] > w_max_age) begin
        w_max_age = r_age[w_idx][w];
        w_old_way = WAY_W'(w);
      end
    end
    w_victim       = w_has_inv ? w_inv_way : w_old_way;
    w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];
  end

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_way    = r_way;
    w_wr_data   = r_wdata;
    w_wr_dirty  = 1'b1;
    w_touch     = 1'b0;
    w_touch_way = r_way;
    case (r_state)
      S_LOOKUP: begin
        if (w_hit) begin
          w_touch     = 1'b1;
          w_touch_way = w_hit_way;
          w_wr_en     = r_is_write;
          w_wr_way    = w_hit_way;
        end else if (r_is_write && !w_victim_dirty) begin
          w_wr_en     = 1'b1;
          w_wr_way    = w_victim;
          w_touch     = 1'b1;
          w_touch_way = w_victim;
        end
      end
      S_WRITEBACK: begin
        if (mem_ready && r_is_write) begin
          w_wr_en = 1'b1;
          w_touch = 1'b1;
        end
      end
      S_FILL: begin
        if (mem_ready) begin
          w_wr_en    = 1'b1;
          w_wr_data  = mem_data_block_flat;
          w_wr_dirty = 1'b0;
          w_touch    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Line arrays; reset discards all contents, dirty data included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_tag[s][w]   <= '0;
          r_data[s][w]  <= '0;
          r_age[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      if (w_wr_en) begin
        r_valid[w_idx][w_wr_way] <= 1'b1;
        r_dirty[w_idx][w_wr_way] <= w_wr_dirty;
        r_tag[w_idx][w_wr_way]   <= w_tag;
        r_data[w_idx][w_wr_way]  <= w_wr_data;
      end
      if (w_touch)
        r_age[w_idx] <= lru_touch(r_age[w_idx], w_touch_way);
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state                <= S_IDLE;
      r_addr                 <= '0;
      r_wdata                <= '0;
      r_is_write             <= 1'b0;
      r_way                  <= '0;
      r_hit                  <= 1'b0;
      r_resp_data            <= '0;
      l1_block_data_out_flat <= '0;
      l1_cache_ready         <= 1'b0;
      l1_cache_hit           <= 1'b0;
      mem_addr               <= '0;
      mem_data_out_flat      <= '0;
      mem_read               <= 1'b0;
      mem_write              <= 1'b0;
    end else begin
      l1_cache_ready <= 1'b0;
      l1_cache_hit   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (l1_cache_write || l1_cache_read) begin
            r_addr     <= l1_cache_addr;
            r_wdata    <= l1_cache_data_in_flat;
            r_is_write <= l1_cache_write;
            r_state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_hit       <= 1'b1;
            r_way       <= w_hit_way;
            r_resp_data <= r_is_write ? r_wdata : r_data[w_idx][w_hit_way];
            r_state     <= S_RESPOND;
          end else begin
            r_hit <= 1'b0;
            r_way <= w_victim;
            if (w_victim_dirty) begin
              mem_write         <= 1'b1;
              mem_addr          <= {r_tag[w_idx][w_victim], w_idx};
              mem_data_out_flat <= r_data[w_idx][w_victim];
              r_state           <= S_WRITEBACK;
            end else if (!r_is_write) begin
              mem_read <= 1'b1;
              mem_addr <= r_addr;
              r_state  <= S_FILL;
            end else begin
              r_resp_data <= r_wdata;
              r_state     <= S_RESPOND;
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            if (r_is_write) begin
              r_resp_data <= r_wdata;
              r_state     <= S_RESPOND;
            end else begin
              // mem_write drops on this same edge, so the two never overlap
              mem_read <= 1'b1;
              mem_addr <= r_addr;
              r_state  <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (mem_ready) begin
            mem_read    <= 1'b0;
            r_resp_data <= mem_data_block_flat;
            r_state     <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          l1_cache_ready         <= 1'b1;
          l1_cache_hit           <= r_hit;
          l1_block_data_out_flat <= r_resp_data;
          r_state                <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef L2_CACHE_WB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hit_count  <= '0;
      perf_miss_count <= '0;
      perf_wb_count   <= '0;
    end else begin
      if (r_state == S_RESPOND) begin
        if (r_hit && (perf_hit_count != '1))
          perf_hit_count <= perf_hit_count + 32'd1;
        if (!r_hit && (perf_miss_count != '1))
          perf_miss_count <= perf_miss_count + 32'd1;
      end
      if ((r_state == S_WRITEBACK) && mem_ready && (perf_wb_count != '1))
        perf_wb_count <= perf_wb_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_cache_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_cache_wb
// Description : Directed self-checking bench for l2_cache_wb configured as a
//               2-way, 2-set cache (index = addr[0]). A memory model inside
//               the access task answers every transfer 3 cycles after it is
//               requested and records the transfer address and data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_cache_wb;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int BS = 8;
  localparam int BW = DW * BS;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] l1_cache_addr;
  logic [BW-1:0] l1_cache_data_in_flat;
  logic          l1_cache_read;
  logic          l1_cache_write;
  logic [BW-1:0] l1_block_data_out_flat;
  logic          l1_cache_ready;
  logic          l1_cache_hit;
  logic [BW-1:0] mem_data_block_flat;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_data_out_flat;
  logic          mem_read;
  logic          mem_write;
`ifdef L2_CACHE_WB_PERF_EN
  logic [31:0]   perf_hit_count;
  logic [31:0]   perf_miss_count;
  logic [31:0]   perf_wb_count;
`endif

  l2_cache_wb #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .CACHE_SIZE(32), .NUM_WAYS(2)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .l1_cache_addr          (l1_cache_addr),
    .l1_cache_data_in_flat  (l1_cache_data_in_flat),
    .l1_cache_read          (l1_cache_read),
    .l1_cache_write         (l1_cache_write),
    .l1_block_data_out_flat (l1_block_data_out_flat),
    .l1_cache_ready         (l1_cache_ready),
    .l1_cache_hit           (l1_cache_hit),
    .mem_data_block_flat    (mem_data_block_flat),
    .mem_ready              (mem_ready),
    .mem_addr               (mem_addr),
    .mem_data_out_flat      (mem_data_out_flat),
    .mem_read               (mem_read),
    .mem_write              (mem_write)
`ifdef L2_CACHE_WB_PERF_EN
    ,
    .perf_hit_count         (perf_hit_count),
    .perf_miss_count        (perf_miss_count),
    .perf_wb_count          (perf_wb_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int both_err = 0;

  // Results of the most recent access
  bit            res_done;
  logic          res_hit;
  logic [BW-1:0] res_data;
  int            res_lat;
  int            n_rd, n_wr;
  logic [AW-1:0] rd_addr_l, wr_addr_l;
  logic [BW-1:0] wr_data_l;
  bit            rd_seen, wr_seen;

  // Issue one request and service memory until l1_cache_ready or timeout.
  task automatic access(input bit is_wr, input logic [AW-1:0] a,
                        input logic [BW-1:0] wd, input logic [BW-1:0] fd);
    int cyc;
    int busy;
    res_done = 0; res_hit = 1'bx; res_data = 'x; res_lat = -1;
    n_rd = 0; n_wr = 0; rd_seen = 0; wr_seen = 0;
    rd_addr_l = 'x; wr_addr_l = 'x; wr_data_l = 'x;
    mem_data_block_flat = fd;
    @(negedge clk);
    l1_cache_addr         = a;
    l1_cache_data_in_flat = wd;
    l1_cache_write        = is_wr;
    l1_cache_read         = !is_wr;
    cyc  = 0;
    busy = 0;
    while (!res_done && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      l1_cache_read  = 1'b0;
      l1_cache_write = 1'b0;
      if (mem_read && mem_write) both_err++;
      if (mem_read)  rd_seen = 1;
      if (mem_write) wr_seen = 1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        busy      = 0;
      end else if (mem_read || mem_write) begin
        busy++;
        if (busy == 3) begin
          if (mem_write) begin
            n_wr++; wr_addr_l = mem_addr; wr_data_l = mem_data_out_flat;
          end else begin
            n_rd++; rd_addr_l = mem_addr;
          end
          mem_ready = 1'b1;
          busy      = 0;
        end
      end
      if (l1_cache_ready) begin
        res_done = 1;
        res_hit  = l1_cache_hit;
        res_data = l1_block_data_out_flat;
        res_lat  = cyc - 1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    l1_cache_addr = '0; l1_cache_data_in_flat = '0;
    l1_cache_read = 1'b0; l1_cache_write = 1'b0;
    mem_data_block_flat = '0; mem_ready = 1'b0;
    #1;
    total++;
    if ({l1_cache_ready, l1_cache_hit, mem_read, mem_write} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b want 0000", {l1_cache_ready, l1_cache_hit, mem_read, mem_write});
    else passed++;
    total++;
    if ({mem_addr, mem_data_out_flat, l1_block_data_out_flat} !== '0)
      $display("FAIL reset_data: got addr=%h wb=%h out=%h want 0", mem_addr, mem_data_out_flat, l1_block_data_out_flat);
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({l1_cache_ready, mem_read, mem_write} !== 3'b000)
      $display("FAIL reset_idle: got %b want 000", {l1_cache_ready, mem_read, mem_write});
    else passed++;
  endtask

  task automatic test_read_miss();
    access(1'b0, 4'd4, '0, {8{8'hAA}});
    total++;
    if (res_done !== 1'b1) $display("FAIL rmiss_done: got %0d want 1", res_done); else passed++;
    total++;
    if (n_rd !== 1 || rd_addr_l !== 4'd4)
      $display("FAIL rmiss_memrd: got n=%0d addr=%0d want n=1 addr=4", n_rd, rd_addr_l);
    else passed++;
    total++;
    if (wr_seen !== 1'b0) $display("FAIL rmiss_nowr: got %0d want 0", wr_seen); else passed++;
    total++;
    if (res_hit !== 1'b0) $display("FAIL rmiss_hit: got %b want 0", res_hit); else passed++;
    total++;
    if (res_data !== {8{8'hAA}}) $display("FAIL rmiss_data: got %h want %h", res_data, {8{8'hAA}}); else passed++;
  endtask

  task automatic test_read_hit();
    access(1'b0, 4'd4, '0, '0);
    total++;
    if (res_lat !== 2) $display("FAIL rhit_lat: got %0d want 2", res_lat); else passed++;
    total++;
    if (res_hit !== 1'b1) $display("FAIL rhit_hit: got %b want 1", res_hit); else passed++;
    total++;
    if (res_data !== {8{8'hAA}}) $display("FAIL rhit_data: got %h want %h", res_data, {8{8'hAA}}); else passed++;
    total++;
    if (rd_seen !== 1'b0) $display("FAIL rhit_nomem: got %0d want 0", rd_seen); else passed++;
  endtask

  task automatic test_write_alloc();
    access(1'b1, 4'd8, {8{8'h55}}, '0);
    total++;
    if (rd_seen !== 1'b0 || wr_seen !== 1'b0)
      $display("FAIL walloc_nomem: got rd=%0d wr=%0d want 0 0", rd_seen, wr_seen);
    else passed++;
    total++;
    if (res_hit !== 1'b0 || res_lat !== 2)
      $display("FAIL walloc_resp: got hit=%b lat=%0d want hit=0 lat=2", res_hit, res_lat);
    else passed++;
    access(1'b0, 4'd8, '0, '0);
    total++;
    if (res_hit !== 1'b1 || res_data !== {8{8'h55}})
      $display("FAIL walloc_readback: got hit=%b data=%h want 1 %h", res_hit, res_data, {8{8'h55}});
    else passed++;
  endtask

  task automatic test_dirty_evict();
    access(1'b0, 4'd4, '0, '0);
    total++;
    if (res_hit !== 1'b1) $display("FAIL devict_touch: got %b want 1", res_hit); else passed++;
    access(1'b1, 4'd12, {8{8'h77}}, '0);
    total++;
    if (n_wr !== 1 || wr_addr_l !== 4'd8)
      $display("FAIL devict_wbaddr: got n=%0d addr=%0d want n=1 addr=8", n_wr, wr_addr_l);
    else passed++;
    total++;
    if (wr_data_l !== {8{8'h55}}) $display("FAIL devict_wbdata: got %h want %h", wr_data_l, {8{8'h55}}); else passed++;
    total++;
    if (rd_seen !== 1'b0) $display("FAIL devict_nord: got %0d want 0", rd_seen); else passed++;
    total++;
    if (res_done !== 1'b1 || res_hit !== 1'b0 || res_data !== {8{8'h77}})
      $display("FAIL devict_resp: got done=%0d hit=%b data=%h want 1 0 %h", res_done, res_hit, res_data, {8{8'h77}});
    else passed++;
  endtask

  task automatic test_clean_evict();
    access(1'b0, 4'd2, '0, {8{8'h33}});
    total++;
    if (wr_seen !== 1'b0) $display("FAIL cevict_nowr: got %0d want 0", wr_seen); else passed++;
    total++;
    if (n_rd !== 1 || rd_addr_l !== 4'd2)
      $display("FAIL cevict_memrd: got n=%0d addr=%0d want n=1 addr=2", n_rd, rd_addr_l);
    else passed++;
    total++;
    if (res_hit !== 1'b0 || res_data !== {8{8'h33}})
      $display("FAIL cevict_resp: got hit=%b data=%h want 0 %h", res_hit, res_data, {8{8'h33}});
    else passed++;
    access(1'b0, 4'd12, '0, '0);
    total++;
    if (res_hit !== 1'b1 || res_data !== {8{8'h77}})
      $display("FAIL cevict_keep12: got hit=%b data=%h want 1 %h", res_hit, res_data, {8{8'h77}});
    else passed++;
  endtask

  task automatic test_reset_mid_wb();
    int cyc;
    // Make addr 12 (dirty) the LRU way of set 0, then miss on addr 14
    access(1'b0, 4'd2, '0, '0);
    total++;
    if (res_hit !== 1'b1) $display("FAIL rmid_prep: got %b want 1", res_hit); else passed++;
`ifdef L2_CACHE_WB_PERF_EN
    total++;
    if (perf_hit_count !== 32'd5 || perf_miss_count !== 32'd4 || perf_wb_count !== 32'd1)
      $display("FAIL perf_counts: got %0d/%0d/%0d want 5/4/1", perf_hit_count, perf_miss_count, perf_wb_count);
    else passed++;
`endif
    @(negedge clk);
    l1_cache_addr = 4'd14;
    l1_cache_read = 1'b1;
    @(negedge clk);
    l1_cache_read = 1'b0;
    cyc = 0;
    while (!mem_write && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (mem_write !== 1'b1 || mem_addr !== 4'd12)
      $display("FAIL rmid_wbstart: got wr=%b addr=%0d want 1 12", mem_write, mem_addr);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_write !== 1'b0) $display("FAIL rmid_async: got %b want 0", mem_write); else passed++;
    total++;
    if ({l1_cache_ready, l1_cache_hit, mem_read, mem_addr, mem_data_out_flat, l1_block_data_out_flat} !== '0)
      $display("FAIL rmid_outs: got rdy=%b rd=%b addr=%h want 0", l1_cache_ready, mem_read, mem_addr);
    else passed++;
`ifdef L2_CACHE_WB_PERF_EN
    total++;
    if ({perf_hit_count, perf_miss_count, perf_wb_count} !== '0)
      $display("FAIL perf_reset: got %0d/%0d/%0d want 0/0/0", perf_hit_count, perf_miss_count, perf_wb_count);
    else passed++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b0, 4'd12, '0, {8{8'h99}});
    total++;
    if (res_hit !== 1'b0 || n_rd !== 1 || rd_addr_l !== 4'd12)
      $display("FAIL rmid_lost: got hit=%b n_rd=%0d addr=%0d want 0 1 12", res_hit, n_rd, rd_addr_l);
    else passed++;
    total++;
    if (wr_seen !== 1'b0 || res_data !== {8{8'h99}})
      $display("FAIL rmid_refill: got wr=%0d data=%h want 0 %h", wr_seen, res_data, {8{8'h99}});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_alloc();
    test_dirty_evict();
    test_clean_evict();
    test_reset_mid_wb();
    total++;
    if (both_err !== 0) $display("FAIL mem_exclusive: got %0d overlaps want 0", both_err); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_cache_wb.md
# l2_cache_wb

Parametrised N-way set-associative, write-back, write-allocate L2 cache with true-LRU replacement. Sits between the L1 cache and main memory and transfers whole blocks on both sides over flat buses. Dirty victims are written back only on eviction; full-block L1 writes allocate without a memory fetch. This replaces the write-through L2 in the memory hierarchy.

## Interface
- DATA_WIDTH, 8, bits per word
- ADDR_WIDTH, 8, block-address width on both the L1 and memory sides
- BLOCK_SIZE, 8, words per block
- CACHE_SIZE, 64, total capacity in words
- NUM_WAYS, 4, associativity; power of 2, at least 2
- Derived: SETS = CACHE_SIZE/(BLOCK_SIZE*NUM_WAYS), a power of 2 and at least 2
- Derived: index = addr[log2(SETS)-1:0]; tag = the remaining upper address bits
- Derived: BW = BLOCK_SIZE*DATA_WIDTH
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  asynchronous active-low reset
- l1_cache_addr  in  ADDR_WIDTH  request block address
- l1_cache_data_in_flat  in  BW  write block
- l1_cache_read  in  1  read request, sampled only in IDLE
- l1_cache_write  in  1  write request, sampled only in IDLE; wins over a simultaneous read
- l1_block_data_out_flat  out  BW  response block, valid while l1_cache_ready is high
- l1_cache_ready  out  1  one-cycle completion pulse
- l1_cache_hit  out  1  request hit; valid with l1_cache_ready
- mem_data_block_flat  in  BW  fill data, sampled when mem_ready is high in FILL
- mem_ready  in  1  memory completes the current transfer
- mem_addr  out  ADDR_WIDTH  memory block address
- mem_data_out_flat  out  BW  writeback data
- mem_read  out  1  fill request level, held until mem_ready
- mem_write  out  1  writeback request level, held until mem_ready

## Operation
- Per line state: valid, dirty, tag, data block, and an LRU age of log2(NUM_WAYS) bits.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL, RESPOND.
- IDLE → LOOKUP: on read or write. Latch the address, the write data, and the operation type.
- LOOKUP, hit:
  - Read: latch the line.
  - Write: overwrite the line, set dirty.
  - Both go to RESPOND with hit=1.
- LOOKUP, miss: choose a victim.
  - Use the lowest-index invalid way if one exists, otherwise the way with the maximum age.
  - Victim valid and dirty → WRITEBACK.
  - Otherwise, read → FILL.
  - Otherwise, write → install the write block, set valid and dirty, go to RESPOND with hit=0.
- WRITEBACK:
  - Drive mem_write=1, mem_addr={victim tag, index}, mem_data_out_flat=victim block.
  - On mem_ready: read → FILL; write → install as above, then RESPOND.
- FILL:
  - Drive mem_read=1, mem_addr=request address.
  - On mem_ready: install mem_data_block_flat, set valid, clear dirty, go to RESPOND with hit=0.
- RESPOND:
  - Drive l1_cache_ready=1.
  - l1_block_data_out_flat is the line contents (the written block for writes).
  - Return to IDLE.
- LRU update on every completed access:
  - The accessed way's age becomes 0.
  - Ways younger than its previous age increment by 1; other ways are unchanged.
- Request inputs are ignored outside IDLE.

## Timing
- Hit: request sampled at edge N; l1_cache_ready is high from edge N+2 to N+3.
- Miss, clean, read: mem_read rises after edge N+1. Ready follows one cycle after mem_ready is sampled.
- Miss, clean, write: same latency as a hit; no memory traffic.
- Dirty miss: the writeback completes fully (mem_write drops) before mem_read rises.
- mem_read and mem_write are never high together.
- mem_ready sampled while neither mem_read nor mem_write is high is ignored.
- Reset values:
  - All outputs 0.
  - All valid and dirty bits 0.
  - Age of way w = w in every set.
  - FSM = IDLE.
- Reset mid-operation: outputs clear asynchronously. Any in-flight transfer is abandoned and all contents, including dirty data, are lost.

## Configuration
- L2_CACHE_WB_PERF_EN defined: adds three output ports, each 32-bit and saturating, and reset to 0.
  - perf_hit_count, incremented in RESPOND when hit=1.
  - perf_miss_count, incremented in RESPOND when hit=0.
  - perf_wb_count, incremented when mem_ready is sampled in WRITEBACK.
- Undefined: these ports and counters are absent. Functional behaviour is identical.

## Test plan
Bench configuration: DATA_WIDTH=8, ADDR_WIDTH=4, BLOCK_SIZE=8, CACHE_SIZE=32, NUM_WAYS=2. This gives SETS=2 and index=addr[0].
1. Read miss at addr 4, memory returns 8'hAA×8 after 3 cycles → mem_read with mem_addr=4; then ready with hit=0 and data AA×8.
2. Read at addr 4 again → ready exactly 2 cycles after the request; hit=1, data AA×8, mem_read never high.
3. Write 8'h55×8 to addr 8 → no mem_read or mem_write, ready with hit=0. A following read of addr 8 gives hit=1, data 55×8.
4. Read 4, then write 8'h77×8 to addr 12 → the dirty LRU victim (addr 8) is written back: mem_write with mem_addr=8, data 55×8. No mem_read follows; ready with hit=0.
5. Read addr 2 → clean LRU victim (addr 4) is evicted; no mem_write; mem_read with mem_addr=2. Addr 12 still hits with 77×8.
6. Drop rst_n while mem_write is high → mem_write=0 immediately. After release, a read of addr 12 misses. With the macro defined, all perf counters read 0.
